// File: rtl/axi_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_slave_pkg
// Shared types and helpers for the AXI4 slave memory responder.
//   - axi_burst_e   : burst type encoding (FIXED / INCR / WRAP, 2'b11 reserved)
//   - OKAY..DECERR  : response codes
//   - wr_state_e    : write channel FSM states
//   - rd_state_e    : read channel FSM states
//   - axi_next_addr : byte address of the beat that follows 'addr'
// -----------------------------------------------------------------------------
package axi_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_e;

    // Reserved encoding: advanced like INCR, answered with SLVERR.
    localparam logic [1:0] BURST_RSVD = 2'b11;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Byte addresses wrap modulo 2^32; WRAP folds back to the aligned window
    // of (len+1) beats that contains the current address.
    function automatic logic [31:0] axi_next_addr(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] total;
        logic [31:0] lower;
        logic [31:0] nxt;
        step  = 32'd1 << size;
        total = ({24'd0, len} + 32'd1) << size;
        lower = addr & ~(total - 32'd1);
        nxt   = addr + step;
        case (burst)
            FIXED:   return addr;
            WRAP:    return (nxt == lower + total) ? lower : nxt;
            default: return nxt;
        endcase
    endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// -----------------------------------------------------------------------------
// axi_slave_mem_ram
// DEPTH x 64-bit memory, one strobed synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clock          : write clock
//   we             : write enable
//   waddr, wstrb   : word index and byte-lane enables of the write
//   wdata          : write data
//   raddr, rdata   : asynchronous read (old data during a same-word write)
// -----------------------------------------------------------------------------
module axi_slave_mem_ram
    import axi_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wstrb,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata
);

    // One byte-wide array per lane keeps each lane a single-writer memory.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clock) begin
                if (we && wstrb[gi]) begin
                    lane_mem[waddr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/axi_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_slave_mem
// AXI4 slave memory responder backed by a MEM_DEPTH x 64-bit RAM starting at
// byte address BASE_ADDR. One outstanding write and one outstanding read, each
// with its own FSM; FIXED/INCR/WRAP bursts with byte strobes.
//   clock, reset            : clock, asynchronous active-high reset
//   aw_* / w_* / b_*        : write address, data and response channels
//   ar_* / r_*              : read address and data channels
//   *_prot/lock/cache/qos   : accepted and ignored
// -----------------------------------------------------------------------------
module axi_slave_mem
    import axi_slave_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [31:0] aw_addr,
    input  logic        aw_id,
    input  logic        aw_user,
    input  logic [7:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_burst,
    input  logic [2:0]  aw_prot,
    input  logic        aw_lock,
    input  logic [3:0]  aw_cache,
    input  logic [3:0]  aw_qos,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [63:0] w_data,
    input  logic [7:0]  w_strb,
    input  logic        w_last,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_resp,
    output logic        b_id,
    output logic        b_user,
    input  logic        ar_valid,
    output logic        ar_ready,
    input  logic [31:0] ar_addr,
    input  logic        ar_id,
    input  logic        ar_user,
    input  logic [7:0]  ar_len,
    input  logic [2:0]  ar_size,
    input  logic [1:0]  ar_burst,
    input  logic [2:0]  ar_prot,
    input  logic        ar_lock,
    input  logic [3:0]  ar_cache,
    input  logic [3:0]  ar_qos,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [63:0] r_data,
    output logic [1:0]  r_resp,
    output logic        r_last,
    output logic        r_id,
    output logic        r_user
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [32:0] SPAN  = 33'(MEM_DEPTH) * 33'd8;

    logic unused_inputs;
    assign unused_inputs = ^{aw_prot, aw_lock, aw_cache, aw_qos,
                             ar_prot, ar_lock, ar_cache, ar_qos};

    // ------------------------------------------------------------- write path
    wr_state_e   wr_state_reg;
    logic [31:0] wr_addr_reg;
    logic [7:0]  wr_len_reg;
    logic [2:0]  wr_size_reg;
    logic [1:0]  wr_burst_reg;
    logic [7:0]  wr_beat_reg;
    logic        wr_len_err_reg;
    logic        wr_dec_err_reg;
    logic        aw_ready_reg;
    logic        w_ready_reg;
    logic        b_valid_reg;
    logic [1:0]  b_resp_reg;
    logic        b_id_reg;
    logic        b_user_reg;

    logic [31:0]      wr_offset;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_len_bad;
    logic [1:0]       wr_resp_final;
    logic             ram_we;

    // Offset comparison handles both bounds at once (below base wraps high).
    assign wr_offset   = wr_addr_reg - BASE_ADDR;
    assign wr_in_range = {1'b0, wr_offset} < SPAN;
    assign wr_idx      = wr_offset[IDX_W+2:3];
    // A beat is wrong when w_last disagrees with "this is beat len".
    assign wr_len_bad  = w_last != (wr_beat_reg == wr_len_reg);
    // Resolved on the w_last beat, including that beat's own conditions.
    assign wr_resp_final = (wr_dec_err_reg || !wr_in_range) ? DECERR :
                           (wr_len_err_reg || wr_len_bad ||
                            wr_burst_reg == BURST_RSVD)   ? SLVERR : OKAY;
    assign ram_we = w_ready_reg && w_valid && wr_in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_reg   <= W_IDLE;
            wr_addr_reg    <= '0;
            wr_len_reg     <= '0;
            wr_size_reg    <= '0;
            wr_burst_reg   <= '0;
            wr_beat_reg    <= '0;
            wr_len_err_reg <= 1'b0;
            wr_dec_err_reg <= 1'b0;
            aw_ready_reg   <= 1'b1;
            w_ready_reg    <= 1'b0;
            b_valid_reg    <= 1'b0;
            b_resp_reg     <= OKAY;
            b_id_reg       <= 1'b0;
            b_user_reg     <= 1'b0;
        end else begin
            case (wr_state_reg)
                W_IDLE: begin
                    if (aw_valid) begin
                        wr_addr_reg    <= aw_addr;
                        wr_len_reg     <= aw_len;
                        wr_size_reg    <= aw_size;
                        wr_burst_reg   <= aw_burst;
                        b_id_reg       <= aw_id;
                        b_user_reg     <= aw_user;
                        wr_beat_reg    <= '0;
                        wr_len_err_reg <= 1'b0;
                        wr_dec_err_reg <= 1'b0;
                        aw_ready_reg   <= 1'b0;
                        w_ready_reg    <= 1'b1;
                        wr_state_reg   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_valid) begin
                        wr_addr_reg <= axi_next_addr(wr_addr_reg, wr_size_reg,
                                                     wr_len_reg, wr_burst_reg);
                        wr_beat_reg <= wr_beat_reg + 8'd1;
                        if (!wr_in_range) wr_dec_err_reg <= 1'b1;
                        if (wr_len_bad)   wr_len_err_reg <= 1'b1;
                        if (w_last) begin
                            w_ready_reg  <= 1'b0;
                            b_valid_reg  <= 1'b1;
                            b_resp_reg   <= wr_resp_final;
                            wr_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        b_valid_reg  <= 1'b0;
                        aw_ready_reg <= 1'b1;
                        wr_state_reg <= W_IDLE;
                    end
                end
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    assign aw_ready = aw_ready_reg;
    assign w_ready  = w_ready_reg;
    assign b_valid  = b_valid_reg;
    assign b_resp   = b_resp_reg;
    assign b_id     = b_id_reg;
    assign b_user   = b_user_reg;

    // -------------------------------------------------------------- read path
    rd_state_e   rd_state_reg;
    logic [31:0] rd_addr_reg;
    logic [7:0]  rd_len_reg;
    logic [2:0]  rd_size_reg;
    logic [1:0]  rd_burst_reg;
    logic [7:0]  rd_beat_reg;
    logic        ar_ready_reg;
    logic        r_valid_reg;
    logic        r_id_reg;
    logic        r_user_reg;

    logic [31:0]      rd_offset;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [63:0]      ram_rdata;

    assign rd_offset   = rd_addr_reg - BASE_ADDR;
    assign rd_in_range = {1'b0, rd_offset} < SPAN;
    assign rd_idx      = rd_offset[IDX_W+2:3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state_reg <= R_IDLE;
            rd_addr_reg  <= '0;
            rd_len_reg   <= '0;
            rd_size_reg  <= '0;
            rd_burst_reg <= '0;
            rd_beat_reg  <= '0;
            ar_ready_reg <= 1'b1;
            r_valid_reg  <= 1'b0;
            r_id_reg     <= 1'b0;
            r_user_reg   <= 1'b0;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    if (ar_valid) begin
                        rd_addr_reg  <= ar_addr;
                        rd_len_reg   <= ar_len;
                        rd_size_reg  <= ar_size;
                        rd_burst_reg <= ar_burst;
                        r_id_reg     <= ar_id;
                        r_user_reg   <= ar_user;
                        rd_beat_reg  <= '0;
                        ar_ready_reg <= 1'b0;
                        r_valid_reg  <= 1'b1;
                        rd_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready) begin
                        if (rd_beat_reg == rd_len_reg) begin
                            r_valid_reg  <= 1'b0;
                            ar_ready_reg <= 1'b1;
                            rd_state_reg <= R_IDLE;
                        end else begin
                            rd_addr_reg <= axi_next_addr(rd_addr_reg, rd_size_reg,
                                                         rd_len_reg, rd_burst_reg);
                            rd_beat_reg <= rd_beat_reg + 8'd1;
                        end
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    // Beat outputs decode from the registered read state, so they stay put
    // for as long as r_ready is held low.
    assign ar_ready = ar_ready_reg;
    assign r_valid  = r_valid_reg;
    assign r_data   = (r_valid_reg && rd_in_range) ? ram_rdata : 64'd0;
    assign r_resp   = !r_valid_reg                  ? OKAY   :
                      !rd_in_range                  ? DECERR :
                      (rd_burst_reg == BURST_RSVD)  ? SLVERR : OKAY;
    assign r_last   = r_valid_reg && (rd_beat_reg == rd_len_reg);
    assign r_id     = r_id_reg;
    assign r_user   = r_user_reg;

    axi_slave_mem_ram #(
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wr_idx),
        .wstrb (w_strb),
        .wdata (w_data),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_slave_mem
// Drives axi_slave_mem with directed and random bursts and compares every
// response against a word-array model of the memory. Beat addresses in the
// model come from closed-form arithmetic over the burst shape.
// -----------------------------------------------------------------------------
module tb_axi_slave_mem;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic        aw_id, aw_user;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [2:0]  aw_prot;
    logic        aw_lock;
    logic [3:0]  aw_cache, aw_qos;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic        b_id, b_user;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic        ar_id, ar_user;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [2:0]  ar_prot;
    logic        ar_lock;
    logic [3:0]  ar_cache, ar_qos;
    logic        r_valid, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last, r_id, r_user;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [DEPTH];
    logic [63:0] wq_data [$];
    logic [7:0]  wq_strb [$];

    always #5 clock = ~clock;

    axi_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .aw_id(aw_id), .aw_user(aw_user), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_prot(aw_prot), .aw_lock(aw_lock),
        .aw_cache(aw_cache), .aw_qos(aw_qos),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .b_id(b_id), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .ar_id(ar_id), .ar_user(ar_user), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_prot(ar_prot), .ar_lock(ar_lock),
        .ar_cache(ar_cache), .ar_qos(ar_qos),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_id(r_id), .r_user(r_user)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Address of beat k of a burst, straight from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input int k);
        logic [31:0] bytes, total, lower;
        bytes = 32'd1 << size;
        total = (32'(len) + 32'd1) * bytes;
        lower = start - (start % total);
        case (burst)
            2'd0:    return start;
            2'd2:    return lower + ((start - lower + 32'(k) * bytes) % total);
            default: return start + 32'(k) * bytes;
        endcase
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 8));
    endfunction

    // Every task starts and ends just after a rising edge.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic id, input logic user,
                               input string tag);
        int n, cnt;
        bit any_oor;
        logic [31:0] a, idx;
        logic [1:0] exp_resp;
        n = wq_data.size();
        any_oor = 0;
        for (int k = 0; k < n; k++) begin
            a = beat_addr(addr, size, len, burst, k);
            if (!in_range(a)) any_oor = 1;
            else begin
                idx = (a - BASE) >> 3;
                for (int b = 0; b < 8; b++)
                    if (wq_strb[k][b]) model_mem[idx][b*8 +: 8] = wq_data[k][b*8 +: 8];
            end
        end
        if (any_oor) exp_resp = 2'b11;
        else if (n != int'(len) + 1 || burst == 2'b11) exp_resp = 2'b10;
        else exp_resp = 2'b00;

        aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        aw_id = id; aw_user = user; aw_valid = 1'b1;
        @(negedge clock); cnt = 0;
        while (!aw_ready && cnt < 50) begin @(negedge clock); cnt++; end
        check({tag, "_aw_wait"}, 64'(cnt < 50), 64'd1);
        @(posedge clock); #1 aw_valid = 1'b0;

        for (int k = 0; k < n; k++) begin
            w_data = wq_data[k]; w_strb = wq_strb[k]; w_last = (k == n - 1); w_valid = 1'b1;
            @(negedge clock); cnt = 0;
            while (!w_ready && cnt < 50) begin @(negedge clock); cnt++; end
            if (cnt >= 50) check({tag, "_w_wait"}, 64'(cnt), 64'd0);
            @(posedge clock); #1;
        end
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;

        @(negedge clock); cnt = 0;
        while (!b_valid && cnt < 50) begin @(negedge clock); cnt++; end
        check({tag, "_b_lat"}, 64'(cnt), 64'd0);
        check({tag, "_b_resp"}, 64'(b_resp), 64'(exp_resp));
        check({tag, "_b_id"}, 64'(b_id), 64'(id));
        check({tag, "_b_user"}, 64'(b_user), 64'(user));
        $display("WR %s addr=%h len=%0d size=%0d burst=%0d beats=%0d b_resp=%0d exp=%0d",
                 tag, addr, len, size, burst, n, b_resp, exp_resp);
        @(posedge clock); #1 b_ready = 1'b0;
        wq_data.delete(); wq_strb.delete();
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic id, input logic user,
                              input int stall_at, input string tag, output logic [63:0] first_data);
        int cnt;
        logic [31:0] a, idx;
        logic [63:0] exp_data;
        logic [1:0] exp_resp;
        first_data = '0;
        ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        ar_id = id; ar_user = user; ar_valid = 1'b1;
        @(negedge clock); cnt = 0;
        while (!ar_ready && cnt < 50) begin @(negedge clock); cnt++; end
        check({tag, "_ar_wait"}, 64'(cnt < 50), 64'd1);
        @(posedge clock); #1 ar_valid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, size, len, burst, i);
            if (in_range(a)) begin
                idx = (a - BASE) >> 3;
                exp_data = model_mem[idx];
                exp_resp = (burst == 2'b11) ? 2'b10 : 2'b00;
            end else begin
                exp_data = '0;
                exp_resp = 2'b11;
            end
            r_ready = (i != stall_at);
            @(negedge clock); cnt = 0;
            while (!r_valid && cnt < 50) begin @(negedge clock); cnt++; end
            if (i == 0) check({tag, "_r_lat"}, 64'(cnt), 64'd0);
            if (i == stall_at) begin
                repeat (3) begin
                    check({tag, "_stall_data"}, r_data, exp_data);
                    check({tag, "_stall_last"}, 64'(r_last), 64'(i == int'(len)));
                    @(negedge clock);
                end
                r_ready = 1'b1;
            end
            check({tag, "_r_data"}, r_data, exp_data);
            check({tag, "_r_resp"}, 64'(r_resp), 64'(exp_resp));
            check({tag, "_r_last"}, 64'(r_last), 64'(i == int'(len)));
            check({tag, "_r_id"}, 64'({r_id, r_user}), 64'({id, user}));
            if (i == 0) first_data = r_data;
            @(posedge clock); #1;
        end
        r_ready = 1'b0;
        @(negedge clock);
        check({tag, "_r_done"}, 64'({r_valid, ar_ready}), 64'b01);
        $display("RD %s addr=%h len=%0d size=%0d burst=%0d stall=%0d first=%h",
                 tag, addr, len, size, burst, stall_at, first_data);
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [31:0] addr, step;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          n, stall;

        reset = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_user = 0; aw_len = 0; aw_size = 0;
        aw_burst = 0; aw_prot = 0; aw_lock = 0; aw_cache = 0; aw_qos = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_user = 0; ar_len = 0; ar_size = 0;
        ar_burst = 0; ar_prot = 0; ar_lock = 0; ar_cache = 0; ar_qos = 0; r_ready = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 64'({aw_ready, ar_ready, w_ready}), 64'b110);
        check("rst_valid", 64'({b_valid, r_valid}), 64'b00);
        check("rst_b", 64'({b_resp, b_id, b_user}), 64'd0);
        check("rst_r", 64'({r_resp, r_last, r_id, r_user}), 64'd0);
        check("rst_rdata", r_data, 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;

        // Fill the whole memory so every later read has a known expectation.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 256; k++) begin
                wq_data.push_back({$urandom, $urandom});
                wq_strb.push_back(8'hFF);
            end
            write_burst(BASE + 32'(f) * 32'd2048, 8'd255, 3'd3, 2'd1, 1'b0, 1'b0, "fill");
        end

        // Single-beat write and read back.
        wq_data.push_back(64'h1122_3344_5566_7788); wq_strb.push_back(8'hFF);
        write_burst(32'h8000_0010, 8'd0, 3'd3, 2'd1, 1'b1, 1'b1, "single");
        read_burst(32'h8000_0010, 8'd0, 3'd3, 2'd1, 1'b1, 1'b0, -1, "single", rd);
        check("single_val", rd, 64'h1122_3344_5566_7788);

        // INCR burst, then lower-half strobe overwrite of word 1.
        for (int k = 0; k < 4; k++) begin
            wq_data.push_back(64'hC0DE_0000_0000_0000 | 64'(k)); wq_strb.push_back(8'hFF);
        end
        write_burst(BASE, 8'd3, 3'd3, 2'd1, 1'b0, 1'b1, "incr4");
        wq_data.push_back(64'hAAAA_AAAA_BBBB_BBBB); wq_strb.push_back(8'h0F);
        write_burst(BASE + 32'd8, 8'd0, 3'd3, 2'd1, 1'b0, 1'b0, "strb");
        read_burst(BASE, 8'd3, 3'd3, 2'd1, 1'b0, 1'b0, -1, "incr4", rd);
        check("incr4_w0", rd, 64'hC0DE_0000_0000_0000);
        read_burst(BASE + 32'd8, 8'd0, 3'd3, 2'd0, 1'b1, 1'b1, -1, "strb", rd);
        check("strb_w1", rd, 64'hC0DE_0000_BBBB_BBBB);

        // WRAP len 3 size 3 from offset 0x30: 32-byte window 0x20..0x3F.
        for (int k = 0; k < 4; k++) begin
            wq_data.push_back(64'hF00D_0000_0000_0000 | 64'(k)); wq_strb.push_back(8'hFF);
        end
        write_burst(BASE + 32'h30, 8'd3, 3'd3, 2'd2, 1'b1, 1'b0, "wrap");
        read_burst(BASE + 32'h30, 8'd3, 3'd3, 2'd2, 1'b0, 1'b0, -1, "wrap", rd);
        read_burst(BASE + 32'h20, 8'd0, 3'd3, 2'd1, 1'b0, 1'b0, -1, "wrap20", rd);
        check("wrap_third_beat", rd, 64'hF00D_0000_0000_0002);
        read_burst(BASE + 32'h38, 8'd0, 3'd3, 2'd1, 1'b0, 1'b0, -1, "wrap38", rd);
        check("wrap_second_beat", rd, 64'hF00D_0000_0000_0001);

        // Out-of-range access.
        read_burst(32'h0000_0100, 8'd0, 3'd3, 2'd1, 1'b1, 1'b1, -1, "oor", rd);
        check("oor_data", rd, 64'd0);
        wq_data.push_back(64'hDEAD_BEEF_DEAD_BEEF); wq_strb.push_back(8'hFF);
        write_burst(32'h0000_0100, 8'd0, 3'd3, 2'd1, 1'b1, 1'b0, "oor");

        // Read backpressure and write length errors.
        read_burst(BASE, 8'd3, 3'd3, 2'd1, 1'b0, 1'b1, 1, "stall", rd);
        for (int k = 0; k < 3; k++) begin
            wq_data.push_back({$urandom, $urandom}); wq_strb.push_back(8'hFF);
        end
        write_burst(BASE + 32'h100, 8'd3, 3'd3, 2'd1, 1'b0, 1'b0, "early_last");
        for (int k = 0; k < 3; k++) begin
            wq_data.push_back({$urandom, $urandom}); wq_strb.push_back(8'hFF);
        end
        write_burst(BASE + 32'h200, 8'd1, 3'd3, 2'd1, 1'b0, 1'b0, "late_last");
        read_burst(BASE + 32'h200, 8'd2, 3'd3, 2'd1, 1'b0, 1'b0, -1, "late_last", rd);

        // Reset in the middle of a write burst: one beat lands, the next does not.
        aw_addr = BASE + 32'h300; aw_len = 8'd3; aw_size = 3'd3; aw_burst = 2'd1;
        aw_id = 1'b1; aw_user = 1'b1; aw_valid = 1'b1;
        @(negedge clock); @(posedge clock); #1 aw_valid = 1'b0;
        w_data = 64'h1234_5678_9ABC_DEF0; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
        @(negedge clock);
        check("rst_mid_wready", 64'(w_ready), 64'd1);
        @(posedge clock); #1;
        model_mem[32'h300 >> 3] = 64'h1234_5678_9ABC_DEF0;
        w_data = 64'h0BAD_0BAD_0BAD_0BAD;
        #2 reset = 1'b1;
        #1;
        check("rst_async_wready", 64'(w_ready), 64'd0);
        check("rst_async_awready", 64'(aw_ready), 64'd1);
        w_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rst_after", 64'({aw_ready, w_ready, b_valid}), 64'b100);
        @(posedge clock); #1;
        wq_data.push_back(64'h5555_6666_7777_8888); wq_strb.push_back(8'hFF);
        write_burst(BASE + 32'h310, 8'd0, 3'd3, 2'd1, 1'b0, 1'b1, "post_rst");
        read_burst(BASE + 32'h300, 8'd2, 3'd3, 2'd1, 1'b1, 1'b0, -1, "post_rst", rd);
        check("post_rst_w0", rd, 64'h1234_5678_9ABC_DEF0);

        // Random bursts, each written then read back with the same shape.
        for (int t = 0; t < 40; t++) begin
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) burst = 2'b11;
            size = 3'($urandom_range(0, 3));
            if (burst == 2'd2) len = 8'((2 << $urandom_range(0, 2)) - 1);
            else len = 8'($urandom_range(0, 7));
            step = 32'd1 << size;
            addr = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd8
                 + (32'($urandom_range(0, 7)) / step) * step;
            if ($urandom_range(0, 7) == 0) addr = $urandom & 32'hFFFF_FFF8;
            n = int'(len) + 1;
            if ($urandom_range(0, 7) == 0) n = int'(len) + 2;
            else if ($urandom_range(0, 7) == 0 && len > 0) n = int'(len);
            for (int k = 0; k < n; k++) begin
                wq_data.push_back({$urandom, $urandom});
                wq_strb.push_back(8'($urandom));
            end
            write_burst(addr, len, size, burst, 1'($urandom), 1'($urandom), "rand");
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            read_burst(addr, len, size, burst, 1'($urandom), 1'($urandom), stall, "rand", rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
